// File: rtl/reaction_time_meter.sv
// Reaction-time meter: arms the external delay counter, times the player's press in prescaled ticks,
// and flags false starts / timeouts. Define BEST_TIME_EN to keep the best (minimum) valid time.
module reaction_time_meter #(
  parameter int WIDTH = 11,
  parameter int DIV   = 1000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Go,
  input  logic             Button,
  output logic             DelayEnable,
  output logic             Busy,
  output logic [WIDTH-1:0] Time,
  output logic             Valid,
  output logic             FalseStart,
  output logic             Timeout,
  output logic [WIDTH-1:0] Best
);

  typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FAULT} state_t;

  localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] TIME_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TIME_LAST = TIME_MAX - WIDTH'(1);

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] time_q, time_d;
  logic             valid_q, valid_d;
  logic             false_start_q, false_start_d;
  logic             timeout_q, timeout_d;
  logic             delay_enable_q, delay_enable_d;
  logic             busy_q, busy_d;
  logic             button_q;
  logic             press_s;
  logic             tick_s;
  logic             arm_s;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    time_d        = time_q;
    valid_d       = valid_q;
    false_start_d = false_start_q;
    timeout_d     = timeout_q;
    arm_s         = 1'b0;
    press_s       = Button & ~button_q;
    tick_s        = (presc_q == PRESC_LAST);

    case (state_q)
      IDLE, DONE, FAULT: begin
        if (Start) arm_s = 1'b1;
      end
      ARMED: begin
        // A press on the same edge as Go is still a false start.
        if (press_s) begin
          state_d       = FAULT;
          false_start_d = 1'b1;
        end else if (Go) begin
          state_d = TIMING;
          presc_d = '0;
        end
      end
      TIMING: begin
        if (press_s) begin
          state_d = DONE;
          valid_d = 1'b1;
        end else begin
          presc_d = tick_s ? '0 : presc_q + PW'(1);
          if (tick_s) begin
            time_d = time_q + WIDTH'(1);
            if (time_q == TIME_LAST) begin
              state_d   = DONE;
              timeout_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (arm_s) begin
      state_d       = ARMED;
      presc_d       = '0;
      time_d        = '0;
      valid_d       = 1'b0;
      false_start_d = 1'b0;
      timeout_d     = 1'b0;
    end

    delay_enable_d = (state_d == ARMED);
    busy_d         = (state_d == ARMED) || (state_d == TIMING);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      time_q         <= '0;
      valid_q        <= 1'b0;
      false_start_q  <= 1'b0;
      timeout_q      <= 1'b0;
      delay_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      button_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      time_q         <= time_d;
      valid_q        <= valid_d;
      false_start_q  <= false_start_d;
      timeout_q      <= timeout_d;
      delay_enable_q <= delay_enable_d;
      busy_q         <= busy_d;
      button_q       <= Button;
    end
  end

  assign DelayEnable = delay_enable_q;
  assign Busy        = busy_q;
  assign Time        = time_q;
  assign Valid       = valid_q;
  assign FalseStart  = false_start_q;
  assign Timeout     = timeout_q;

`ifdef BEST_TIME_EN
  logic [WIDTH-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if ((state_q == TIMING) && (state_d == DONE) && valid_d && (time_d < best_q)) begin
      best_d = time_d;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) best_q <= TIME_MAX;
    else       best_q <= best_d;
  end

  assign Best = best_q;
`else
  assign Best = TIME_MAX;
`endif

endmodule

// File: tb/tb_reaction_time_meter.sv
// Directed self-checking bench: main instance WIDTH=11/DIV=4, second instance WIDTH=4/DIV=1 for saturation.
module tb_reaction_time_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, go, button;
  logic        de, busy, valid, fs, to;
  logic [10:0] tm, best;
  logic        start4, go4, button4;
  logic        de4, busy4, valid4, fs4, to4;
  logic [3:0]  tm4, best4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reaction_time_meter #(.WIDTH(11), .DIV(4)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .Go(go), .Button(button),
    .DelayEnable(de), .Busy(busy), .Time(tm), .Valid(valid),
    .FalseStart(fs), .Timeout(to), .Best(best)
  );

  reaction_time_meter #(.WIDTH(4), .DIV(1)) dut4 (
    .Clock(clk), .Reset(rst), .Start(start4), .Go(go4), .Button(button4),
    .DelayEnable(de4), .Busy(busy4), .Time(tm4), .Valid(valid4),
    .FalseStart(fs4), .Timeout(to4), .Best(best4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Start, Go, then press so the frozen value is k ticks (press sampled at t0+4k+1).
  task automatic round(input int k, input logic [10:0] exp_best);
    arm();
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (4 * k) tick();
    button = 1'b1;
    tick();
    button = 1'b0;
    check("round_time", 32'(tm), 32'(k));
    check("round_valid", 32'(valid), 32'd1);
    check("round_best", 32'(best), 32'(exp_best));
  endtask

  initial begin
    logic [10:0] b10, b2, b6, b6b;
`ifdef BEST_TIME_EN
    b10 = 11'd10; b2 = 11'd2; b6 = 11'd6; b6b = 11'd6;
`else
    b10 = 11'd2047; b2 = 11'd2047; b6 = 11'd2047; b6b = 11'd2047;
`endif
    rst = 1'b1; start = 1'b0; go = 1'b0; button = 1'b0;
    start4 = 1'b0; go4 = 1'b0; button4 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_time", 32'(tm), 32'd0);
    check("rst_flags", {28'd0, valid, fs, to, de}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_best", 32'(best), 32'd2047);

    // 1: nominal round, press at t0+41 -> 10 ticks
    arm();
    check("t1_de", 32'(de), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("t1_de_drop", 32'(de), 32'd0);
    check("t1_timing_busy", 32'(busy), 32'd1);
    repeat (40) tick();
    check("t1_time_run", 32'(tm), 32'd10);
    button = 1'b1;
    tick();
    button = 1'b0;
    check("t1_time", 32'(tm), 32'd10);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_best", 32'(best), 32'(b10));
    repeat (6) tick();
    check("t1_hold", 32'(tm), 32'd10);

    // 2: false start, later Go ignored
    arm();
    check("t2_clear_time", 32'(tm), 32'd0);
    check("t2_clear_valid", 32'(valid), 32'd0);
    button = 1'b1;
    tick();
    button = 1'b0;
    check("t2_fs", 32'(fs), 32'd1);
    check("t2_valid", 32'(valid), 32'd0);
    check("t2_de", 32'(de), 32'd0);
    go = 1'b1;
    tick(); tick();
    go = 1'b0;
    check("t2_stay_fault", {29'd0, fs, busy, de}, 32'd4);

    // 3: button held across Start is not a press
    button = 1'b1;
    tick();
    arm();
    check("t3_fs_clear", 32'(fs), 32'd0);
    check("t3_de", 32'(de), 32'd1);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("t3_no_fs", 32'(fs), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    button = 1'b0;
    tick();
    repeat (7) tick();
    button = 1'b1;
    tick();
    button = 1'b0;
    check("t3_time", 32'(tm), 32'd2);
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_best", 32'(best), 32'(b2));

    // 4: WIDTH=4 DIV=1 saturation, then press on the would-saturate cycle
    start4 = 1'b1; tick(); start4 = 1'b0;
    go4 = 1'b1; tick(); go4 = 1'b0;
    repeat (14) tick();
    check("t4_time14", 32'(tm4), 32'd14);
    check("t4_no_to_yet", {30'd0, to4, busy4}, 32'd1);
    tick();
    check("t4_time15", 32'(tm4), 32'd15);
    check("t4_timeout", 32'(to4), 32'd1);
    check("t4_valid", 32'(valid4), 32'd0);
    check("t4_busy", 32'(busy4), 32'd0);
    repeat (3) tick();
    check("t4_hold", {27'd0, tm4, to4}, 32'd31);
    start4 = 1'b1; tick(); start4 = 1'b0;
    check("t4_rearm_clear", {27'd0, tm4, to4}, 32'd0);
    go4 = 1'b1; tick(); go4 = 1'b0;
    repeat (14) tick();
    button4 = 1'b1; tick(); button4 = 1'b0;
    check("t4_late_valid", 32'(valid4), 32'd1);
    check("t4_late_to", 32'(to4), 32'd0);
    check("t4_late_time", 32'(tm4), 32'd14);

    // 5: press and Go together, then reset mid-TIMING
    arm();
    go = 1'b1; button = 1'b1;
    tick();
    go = 1'b0; button = 1'b0;
    check("t5_fs", 32'(fs), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    arm();
    go = 1'b1; tick(); go = 1'b0;
    repeat (10) tick();
    check("t5_time_pre", 32'(tm), 32'd2);
    rst = 1'b1;
    #1;
    check("t5_rst_time", 32'(tm), 32'd0);
    check("t5_rst_flags", {27'd0, valid, fs, to, de, busy}, 32'd0);
    check("t5_rst_best", 32'(best), 32'd2047);
    tick();
    rst = 1'b0;
    tick();
    check("t5_idle", 32'(busy), 32'd0);

    // 6: best tracking
    round(10, b10);
    round(6, b6);
    round(8, b6b);
    arm();
    button = 1'b1; tick(); button = 1'b0;
    check("t6_fs", 32'(fs), 32'd1);
    check("t6_best_kept", 32'(best), 32'(b6));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
